// File: rtl/led_mode_ctrl.sv
// Front-panel pushbutton stage ahead of LEDGen: synchronises and debounces two
// buttons, toggles the LED enable and steps/clears the pattern mode.
module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode_raw,
  input  logic       btn_en_raw,
  output logic       enable,
  output logic [1:0] mode,
  output logic       mode_changed
);

  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_EN   = 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_e;

  logic [1:0]      raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync_q;
  logic [1:0]      db_q;
  logic [1:0]      db_d;
  logic [1:0]      db_prev_q;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  logic mode_rise;
  logic mode_fall;
  logic en_rise;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              enable_q;
  logic [1:0]        mode_q;
  logic              mode_changed_q;

  assign raw[BTN_MODE] = btn_mode_raw;
  assign raw[BTN_EN]   = btn_en_raw;

  // The counter counts cycles of disagreement; the level only moves on the
  // cycle after the count has already reached DEBOUNCE_CYCLES.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          db_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= raw;
      sync_q    <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  assign mode_rise = db_q[BTN_MODE] & ~db_prev_q[BTN_MODE];
  assign mode_fall = ~db_q[BTN_MODE] & db_prev_q[BTN_MODE];
  assign en_rise   = db_q[BTN_EN] & ~db_prev_q[BTN_EN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      enable_q       <= 1'b0;
      mode_q         <= '0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_changed_q <= 1'b0;
      if (en_rise) begin
        enable_q <= ~enable_q;
      end
      case (state_q)
        IDLE: begin
          if (mode_rise) begin
            state_q <= PRESSED;
            hold_q  <= '0;
          end
        end
        PRESSED: begin
          if (mode_fall) begin
            mode_q         <= mode_q + 2'd1;
            mode_changed_q <= 1'b1;
            state_q        <= IDLE;
          end else if (hold_q == HOLD_MAX) begin
            mode_q         <= '0;
            mode_changed_q <= 1'b1;
            state_q        <= HELD;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        HELD: begin
          if (mode_fall) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enable       = enable_q;
  assign mode         = mode_q;
  assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: directed scenarios with fixed expected
// timing, then randomized button activity against a behavioural model.
module tb_led_mode_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned H = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode_raw;
  logic       btn_en_raw;
  logic       enable;
  logic [1:0] mode;
  logic       mode_changed;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode_raw(btn_mode_raw),
    .btn_en_raw  (btn_en_raw),
    .enable      (enable),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  // Behavioural model. Index 0 = mode button, 1 = enable button.
  // A raw level is seen two samples late; the debounced level adopts it once
  // it has disagreed for D+1 consecutive samples. m_age >= 0 is an open press.
  int m_s1[2], m_s[2], m_db[2], m_dbp[2], m_run[2];
  int m_age;
  bit m_held;
  int m_mode;
  bit m_en;
  bit m_pulse;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_run[b] = 0;
    end
    m_age = -1; m_held = 1'b0; m_mode = 0; m_en = 1'b0; m_pulse = 1'b0;
  endfunction

  function automatic void model_step();
    int raw[2];
    bit rise[2];
    bit fall[2];
    if (reset !== 1'b1) begin
      model_reset();
      return;
    end
    raw[0] = int'(btn_mode_raw);
    raw[1] = int'(btn_en_raw);
    for (int b = 0; b < 2; b++) begin
      rise[b] = (m_db[b] == 1) && (m_dbp[b] == 0);
      fall[b] = (m_db[b] == 0) && (m_dbp[b] == 1);
    end
    m_pulse = 1'b0;
    if (rise[1]) m_en = !m_en;
    if (m_age >= 0) begin
      if (fall[0]) begin
        m_mode = (m_mode + 1) % 4; m_pulse = 1'b1; m_age = -1;
      end else if (m_age == int'(H)) begin
        m_mode = 0; m_pulse = 1'b1; m_age = -1; m_held = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_held) begin
      if (fall[0]) m_held = 1'b0;
    end else if (rise[0]) begin
      m_age = 0;
    end
    for (int b = 0; b < 2; b++) begin
      m_dbp[b] = m_db[b];
      if (m_s[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] > int'(D)) begin
          m_db[b] = m_s[b]; m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s[b]  = m_s1[b];
      m_s1[b] = raw[b];
    end
  endfunction

  // One clock: the model advances on the active edge, callers sample and drive
  // on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic hold_btns(input bit m, input bit e, input int n);
    btn_mode_raw = m;
    btn_en_raw   = e;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (enable !== 1'b0) $display("FAIL reset_enable: got %b required 0", enable);
    else n_pass++;
    n_checks++;
    if (mode !== 2'd0) $display("FAIL reset_mode: got %0d required 0", mode);
    else n_pass++;
    n_checks++;
    if (mode_changed !== 1'b0) $display("FAIL reset_mode_changed: got %b required 0", mode_changed);
    else n_pass++;
    reset = 1'b1;
    repeat (5) tick();
    n_checks++;
    if ({enable, mode, mode_changed} !== 4'b0)
      $display("FAIL reset_idle: got en=%b mode=%0d mc=%b required all 0", enable, mode, mode_changed);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int p = 0; p < 5; p++) begin
      btn_en_raw = 1'b1;
      repeat (3) begin tick(); if (enable !== 1'b0) bad++; end
      btn_en_raw = 1'b0;
      repeat (3) begin tick(); if (enable !== 1'b0) bad++; end
    end
    repeat (10) begin tick(); if (enable !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL bounce_reject: enable high on %0d cycles, required 0", bad);
    else n_pass++;
    btn_en_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (enable !== 1'(k >= 7))
        $display("FAIL bounce_latency k=%0d: got %b required %b", k, enable, 1'(k >= 7));
      else n_pass++;
    end
    btn_en_raw = 1'b0;
    bad = 0;
    repeat (12) begin tick(); if (enable !== 1'b1) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL bounce_release: enable low on %0d cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_short_press();
    int pulses = 0;
    int bad = 0;
    logic [1:0] exp_mode = 2'd0;
    for (int p = 0; p < 4; p++) begin
      btn_mode_raw = 1'b1;
      repeat (10) begin
        tick();
        if (mode_changed !== 1'b0 || mode !== exp_mode) bad++;
      end
      btn_mode_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (k == 7) exp_mode = 2'(p + 1);
        if (mode_changed === 1'b1) pulses++;
        if (mode_changed !== 1'(k == 7) || mode !== exp_mode) bad++;
      end
      n_checks++;
      if (mode !== 2'(p + 1)) $display("FAIL short_mode press %0d: got %0d required %0d", p, mode, 2'(p + 1));
      else n_pass++;
    end
    n_checks++;
    if (pulses != 4) $display("FAIL short_pulses: got %0d required 4", pulses);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL short_timing: %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_long_press();
    int bad = 0;
    int pulses = 0;
    repeat (2) begin hold_btns(1'b1, 1'b0, 10); hold_btns(1'b0, 1'b0, 10); end
    n_checks++;
    if (mode !== 2'd2) $display("FAIL long_pre_mode: got %0d required 2", mode);
    else n_pass++;
    for (int r = 0; r < 2; r++) begin
      btn_mode_raw = 1'b1;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (mode_changed === 1'b1) pulses++;
        if (mode_changed !== 1'(k == 28)) bad++;
        if (mode !== ((r == 0 && k < 28) ? 2'd2 : 2'd0)) bad++;
      end
      btn_mode_raw = 1'b0;
      repeat (15) begin
        tick();
        if (mode_changed !== 1'b0 || mode !== 2'd0) bad++;
      end
    end
    n_checks++;
    if (pulses != 2) $display("FAIL long_pulses: got %0d required 2", pulses);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL long_timing: %0d bad cycles, required 0", bad);
    else n_pass++;
    n_checks++;
    if (mode !== 2'd0) $display("FAIL long_final_mode: got %0d required 0", mode);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int bad = 0;
    hold_btns(1'b0, 1'b1, 10); hold_btns(1'b0, 1'b0, 10);
    hold_btns(1'b1, 1'b0, 10); hold_btns(1'b0, 1'b0, 10);
    n_checks++;
    if (enable !== 1'b0 || mode !== 2'd1)
      $display("FAIL simul_pre: got en=%b mode=%0d required en=0 mode=1", enable, mode);
    else n_pass++;
    btn_mode_raw = 1'b1; btn_en_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (enable !== 1'(k >= 7)) bad++;
      if (mode !== 2'd1 || mode_changed !== 1'b0) bad++;
    end
    btn_mode_raw = 1'b0; btn_en_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mode_changed !== 1'(k == 7)) bad++;
      if (mode !== ((k >= 7) ? 2'd2 : 2'd1)) bad++;
      if (enable !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL simul_timing: %0d bad cycles, required 0", bad);
    else n_pass++;
    n_checks++;
    if (enable !== 1'b1 || mode !== 2'd2)
      $display("FAIL simul_post: got en=%b mode=%0d required en=1 mode=2", enable, mode);
    else n_pass++;
    // Mode release and enable press debounce on the same cycle.
    hold_btns(1'b1, 1'b0, 10);
    btn_mode_raw = 1'b0; btn_en_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 6) begin
        n_checks++;
        if ({enable, mode, mode_changed} !== {1'b1, 2'd2, 1'b0})
          $display("FAIL same_cycle_before: got en=%b mode=%0d mc=%b required en=1 mode=2 mc=0", enable, mode, mode_changed);
        else n_pass++;
      end
      if (k == 7) begin
        n_checks++;
        if ({enable, mode, mode_changed} !== {1'b0, 2'd3, 1'b1})
          $display("FAIL same_cycle_after: got en=%b mode=%0d mc=%b required en=0 mode=3 mc=1", enable, mode, mode_changed);
        else n_pass++;
      end
    end
    hold_btns(1'b0, 1'b0, 10);
  endtask

  task automatic test_reset_midrun();
    int bad = 0;
    hold_btns(1'b0, 1'b1, 10); hold_btns(1'b0, 1'b0, 10);
    repeat (3) begin hold_btns(1'b1, 1'b0, 10); hold_btns(1'b0, 1'b0, 10); end
    n_checks++;
    if (enable !== 1'b1 || mode !== 2'd2)
      $display("FAIL midrun_pre: got en=%b mode=%0d required en=1 mode=2", enable, mode);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (enable !== 1'b0) $display("FAIL midrun_enable: got %b required 0", enable);
    else n_pass++;
    n_checks++;
    if (mode !== 2'd0) $display("FAIL midrun_mode: got %0d required 0", mode);
    else n_pass++;
    n_checks++;
    if (mode_changed !== 1'b0) $display("FAIL midrun_mode_changed: got %b required 0", mode_changed);
    else n_pass++;
    repeat (5) begin tick(); if ({enable, mode, mode_changed} !== 4'b0) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL midrun_hold: %0d nonzero cycles, required 0", bad);
    else n_pass++;
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_midpress();
    int bad = 0;
    btn_mode_raw = 1'b1; btn_en_raw = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (enable !== 1'b1 || mode !== 2'd0)
      $display("FAIL midpress_pre: got en=%b mode=%0d required en=1 mode=0", enable, mode);
    else n_pass++;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mode_changed !== 1'b0 || mode !== 2'd0) bad++;
      if (enable !== 1'(k >= 7)) bad++;
    end
    btn_mode_raw = 1'b0; btn_en_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mode_changed !== 1'(k == 7)) bad++;
      if (mode !== ((k >= 7) ? 2'd1 : 2'd0)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL midpress_timing: %0d bad cycles, required 0", bad);
    else n_pass++;
    n_checks++;
    if (mode !== 2'd1 || enable !== 1'b1)
      $display("FAIL midpress_post: got en=%b mode=%0d required en=1 mode=1", enable, mode);
    else n_pass++;
  endtask

  task automatic test_random();
    int left[2];
    bit lvl[2];
    left[0] = 0; left[1] = 0;
    lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int c = 0; c < 900; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = !lvl[b];
          left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
        end
        left[b]--;
      end
      btn_mode_raw = lvl[0];
      btn_en_raw   = lvl[1];
      tick();
      n_checks++;
      if (enable !== m_en) $display("FAIL rand_enable cycle %0d: got %b required %b", c, enable, m_en);
      else n_pass++;
      n_checks++;
      if (mode !== 2'(m_mode)) $display("FAIL rand_mode cycle %0d: got %0d required %0d", c, mode, m_mode);
      else n_pass++;
      n_checks++;
      if (mode_changed !== m_pulse)
        $display("FAIL rand_mode_changed cycle %0d: got %b required %b", c, mode_changed, m_pulse);
      else n_pass++;
    end
    hold_btns(1'b0, 1'b0, 20);
  endtask

  initial begin
    reset        = 1'b0;
    btn_mode_raw = 1'b0;
    btn_en_raw   = 1'b0;
    model_reset();
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_simultaneous();
    test_reset_midrun();
    test_reset_midpress();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Front-panel control stage that sits directly upstream of LEDGen and drives its enable and mode[1:0] inputs from two raw board pushbuttons. Each button is synchronised and debounced. A short press of the mode button advances the pattern mode (0→1→2→3→0). A long press returns the mode to 0. A press of the enable button toggles LED output on and off. A one-cycle mode_changed pulse is provided for status/seven-segment logic.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced level change (10 ms at 100 MHz); must be ≥ 2
HOLD_CYCLES, 100_000_000, press duration (from debounced rise) that counts as a long press (1 s at 100 MHz); must be > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_mode_raw  input  1  raw, asynchronous, bouncing mode pushbutton, 1 = pressed
btn_en_raw  input  1  raw, asynchronous, bouncing enable pushbutton, 1 = pressed
enable  output  1  registered LED enable to LEDGen
mode  output  2  registered pattern select to LEDGen
mode_changed  output  1  one-cycle pulse when mode is written

Behaviour:
- Reset (reset=0, async): enable=0, mode=2'b00, mode_changed=0; synchronisers, debounced levels and counters = 0; mode FSM = IDLE. Deassertion takes effect on the next clk edge.
- Synchroniser: each raw button passes through a 2-flop synchroniser, giving btn_x_s.
- Debounce, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while btn_x_s != btn_x_db; it clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, btn_x_db takes btn_x_s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_x_db.
- Edge detect: rise/fall are a one-cycle compare of btn_x_db against its previous value.
- Enable path: enable toggles on the cycle after btn_en_db rises. Release has no effect.
- Latency: from the first clk edge that samples raw high (held stable), output changes DEBOUNCE_CYCLES+3 cycles later.
- Mode FSM (states IDLE, PRESSED, HELD):
  - IDLE: on btn_mode_db rise → PRESSED, hold counter = 0.
  - PRESSED: hold counter increments each cycle; it is sized $clog2(HOLD_CYCLES+1) and saturates.
    - btn_mode_db falls before the counter reaches HOLD_CYCLES: mode ← mode+1 (2-bit wrap, 3→0), pulse mode_changed, → IDLE.
    - Counter reaches HOLD_CYCLES while still pressed: mode ← 0, pulse mode_changed (even if mode was already 0), → HELD.
  - HELD: no mode changes. On btn_mode_db fall → IDLE. Release from HELD does not increment.
- mode_changed: high for exactly one cycle, the same cycle mode takes its new value; otherwise 0.
- Simultaneous events: the two buttons are fully independent. A toggle and a mode change may occur in the same cycle; both take effect.
- Reset mid-press: all state is lost. A button still held at reset release must first be seen debounced-high, which requires a full debounce (debounced level starts at 0). That debounced rise then counts as a new press.
- enable does not gate mode changes. Mode may be advanced while LEDs are disabled.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, 10 ns clk.
1. Reset: assert reset=0 mid-run with mode=2, enable=1 → outputs immediately enable=0, mode=0, mode_changed=0. They hold while reset=0.
2. Bounce rejection:
   - Toggle btn_en_raw with 3-cycle pulses ×5, then hold low → enable stays 0.
   - Hold high 10 cycles → enable=1 exactly 7 cycles after the first edge sampling high; no further change on release.
3. Short presses: four presses of btn_mode_raw, each 10 cycles high and 10 low → mode sequence 1,2,3,0. mode_changed is high exactly 4 times, each for 1 cycle, coinciding with the mode update after debounced fall.
4. Long press: with mode=2, hold btn_mode_raw for 40 cycles → mode=0 with one mode_changed pulse ~20 cycles after debounced rise. Release → no further change; mode stays 0.
5. Simultaneous: press both buttons together for 10 cycles from mode=1, enable=0 → enable=1 on rise; mode=2 on release. Neither output is lost.
6. Reset mid-press: assert reset during PRESSED with btn_mode_raw held, then release reset while still held → no mode change until a full debounce; the later release increments mode 0→1.
